// File: rtl/comparator_nbit_seq_pkg.sv
// Shared types and constants for the sequential slice-by-slice magnitude comparator.
// Covers FSM states, one-hot result codes and slice-count derivation.
package comparator_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  // Result order is {smaller, equal, greater}
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // Returns the slice count, or 0 when the geometry is illegal.
  function automatic int calc_nslice(input int width, input int slice);
    if (slice < 1 || slice > width || (width % slice) != 0) begin
      return 0;
    end
    return width / slice;
  endfunction

endpackage

// File: rtl/comparator_nbit_seq_if.sv
// Start/busy/done handshake and operand/result bundle of the sequential comparator.
interface comparator_nbit_seq_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             smaller;
  logic             equal;
  logic             greater;

  modport master (
    output start, a, b, is_signed,
    input  busy, done, smaller, equal, greater
  );

  modport slave (
    input  start, a, b, is_signed,
    output busy, done, smaller, equal, greater
  );

endinterface

// File: rtl/comparator_nbit_seq_slice_compare.sv
// Combinational compare of one slice; msb_invert turns the top slice into a signed compare.
module slice_compare #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             msb_invert,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic [SLICE-1:0] inv_mask;
  logic [SLICE-1:0] a_x;
  logic [SLICE-1:0] b_x;

  always_comb begin
    inv_mask            = '0;
    inv_mask[SLICE-1]   = msb_invert;
  end

  // Flipping the sign bit maps two's complement order onto unsigned order
  assign a_x = a_s ^ inv_mask;
  assign b_x = b_s ^ inv_mask;

  assign lt = (a_x <  b_x);
  assign eq = (a_x == b_x);
  assign gt = (a_x >  b_x);

endmodule

// File: rtl/comparator_nbit_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator: walks slices MSB-first, exits at the
// first differing slice, and reports a registered one-hot result with a done pulse.
module comparator_nbit_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  comparator_nbit_seq_if.slave bus
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (NSLICE < 1) begin : g_bad_geometry
      $error("comparator_nbit_seq: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              signed_q, signed_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [2:0]        res_q, res_d;
  logic              done_q, done_d;

  logic [SLICE-1:0]  a_slices [NSLICE];
  logic [SLICE-1:0]  b_slices [NSLICE];
  logic [SLICE-1:0]  a_sel;
  logic [SLICE-1:0]  b_sel;
  logic              top_slice;
  logic              s_lt, s_eq, s_gt;

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slices
      assign a_slices[gi] = a_q[gi*SLICE +: SLICE];
      assign b_slices[gi] = b_q[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_sel     = a_slices[idx_q];
  assign b_sel     = b_slices[idx_q];
  assign top_slice = (idx_q == IDXW'(NSLICE - 1));

  slice_compare #(
    .SLICE (SLICE)
  ) u_slice_compare (
    .a_s        (a_sel),
    .b_s        (b_sel),
    .msb_invert (signed_q & top_slice),
    .lt         (s_lt),
    .eq         (s_eq),
    .gt         (s_gt)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    res_d    = res_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = COMPARE;
          a_d      = bus.a;
          b_d      = bus.b;
          signed_d = bus.is_signed;
          idx_d    = IDXW'(NSLICE - 1);
          res_d    = RES_NONE;
        end
      end
      COMPARE: begin
        if (!s_eq) begin
          res_d   = s_lt ? RES_LT : (s_gt ? RES_GT : RES_NONE);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      res_q    <= RES_NONE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q == COMPARE);
  assign bus.done = done_q;
  assign {bus.smaller, bus.equal, bus.greater} = res_q;

endmodule

// File: doc/comparator_nbit_seq.md
Name: comparator_nbit_seq

Overview:
Parametrised, multi-cycle magnitude comparator; successor to the 1-bit comparator with the same smaller/equal/greater result outputs.
- Compares two WIDTH-bit operands MSB-first, one SLICE-bit slice per clock.
- Terminates early at the first differing slice.
- Supports signed (two's complement) and unsigned modes.
- Uses a start/busy/done handshake.
- Used where wide compares must not sit in a single-cycle critical path.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of SLICE.
- SLICE, 4, bits compared per cycle; 1 <= SLICE <= WIDTH.
- NSLICE, WIDTH/SLICE, derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request compare; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- is_signed  input  1  1=two's complement compare, 0=unsigned; captured on the accepted start.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse; result outputs valid from this cycle.
- smaller  output  1  A < B.
- equal  output  1  A == B.
- greater  output  1  A > B.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy, done, smaller, equal, greater all 0; captured operands cleared. Reset mid-compare aborts silently with no done pulse.
- FSM states: IDLE, COMPARE.
- IDLE -> COMPARE when start=1 at an edge.
  - On that edge: register a, b, is_signed; slice index idx=NSLICE-1 (MSB slice); busy=1.
- COMPARE, each cycle: slice idx of A and B is compared combinationally.
  - Slices differ: at the next edge register the result, pulse done=1, clear busy, go to IDLE.
  - Slices equal, idx>0: decrement idx, stay in COMPARE.
  - Slices equal, idx==0: register equal=1, pulse done, go to IDLE.
- Signed mode: the top slice is compared with its MSB inverted on both operands; lower slices are always unsigned.
- Latency: start accepted at edge E0; done is high in the cycle after edge Ek.
  - k = number of slices examined, 1..NSLICE.
  - Worst case NSLICE cycles; an equal result always takes NSLICE cycles.
- Result outputs:
  - Registered and exactly one-hot after the first completed compare.
  - Held until the next accepted start, where they clear to 000 for the duration of busy.
  - Read them when done=1 or later.
- done: exactly one cycle wide per completed compare.
- start while busy=1: ignored; the operation in flight is not disturbed.
- start during the done cycle: accepted (state is IDLE), so back-to-back compares are possible with zero bubble.
- a, b, is_signed changing while busy: no effect on the compare in flight.
- WIDTH==SLICE: degenerates to a registered single-cycle compare with latency 1.

Decomposition:
- Package comparator_pkg:
  - FSM state typedef (IDLE, COMPARE).
  - Result one-hot encoding constants (RES_LT=3'b100, RES_EQ=3'b010, RES_GT=3'b001, order {smaller,equal,greater}).
  - Function computing NSLICE and checking the WIDTH % SLICE == 0 constraint for elaboration.
- One combinational sub-module, slice_compare:
  - Parameter SLICE; inputs a_s, b_s, msb_invert; outputs lt, eq, gt.
  - Instantiated once and fed through a slice mux indexed by idx.

Test Plan (WIDTH=16, SLICE=4):
- Reset with rst_n=0 for 2 cycles -> busy=done=smaller=equal=greater=0; start asserted during reset is ignored.
- Unsigned, a=16'h1234, b=16'h1234 -> done 4 cycles after accepted start; equal=1, smaller=greater=0.
- Unsigned, a=16'h9000, b=16'h1000 -> done after 1 cycle, greater=1. Same operands signed -> done after 1 cycle, smaller=1. Signed a=16'hFFFF, b=16'hFFFE -> 4 cycles, greater=1.
- Early-exit depth: a=16'h0F00, b=16'h0E00 -> 2 cycles, greater=1; a=16'h00A5, b=16'h00A6 -> 4 cycles, smaller=1.
- Handshake:
  - start re-pulsed with new operands while busy -> ignored; the original result is reported.
  - start held high through the done cycle with a=16'h0001, b=16'h0002 -> second compare accepted with no idle cycle.
  - Results clear to 000 while busy, then smaller=1 after 4 cycles.
- Reset mid-operation: rst_n=0 on the 2nd COMPARE cycle of a=16'h1234, b=16'h1235 -> all outputs 0 next cycle, no done pulse; a new start after reset completes normally.
